// File: rtl/dm_access_arbiter_pkg.sv
// Shared encodings for the data-memory access arbiter.
// Contents: FSM state encoding, port-owner encoding, wait counter width
// and a saturating increment helper for that counter.
package dm_access_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_NORM  = 2'd0,
        ARB_FORCE = 2'd1,
        ARB_ACK   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DEV  = 2'd2
    } arb_owner_t;

    localparam int WAIT_W = 3;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dm_access_arbiter_if.sv
// Bundle of the CPU Mem-stage, secondary device and data-memory signals
// around the DM access arbiter.
//   master: requester/memory side (drives cpu_*, dev_* requests, dm_rdata)
//   slave : the arbiter (drives cpu_rdata/cpu_stall, dev_ack/dev_rdata, dm_*)
// Device handshake: dev_req rises with stable dev_we/addr/wdata/be and is
// held, fields unchanged, until dev_ack; dev_ack is a one-cycle pulse in the
// cycle after the grant and dev_rdata is valid only while dev_ack=1. A
// request dropped before its grant is forgotten without an ack.
interface dm_access_arbiter_if;
    logic        cpu_valid;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [3:0]  cpu_be;
    logic        cpu_err;
    logic [31:0] cpu_pc;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        dev_req;
    logic        dev_we;
    logic [31:0] dev_addr;
    logic [31:0] dev_wdata;
    logic [3:0]  dev_be;
    logic        dev_ack;
    logic [31:0] dev_rdata;

    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_we;
    logic [31:0] dm_pc;
    logic [31:0] dm_rdata;

    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_be, cpu_err, cpu_pc,
        input  cpu_rdata, cpu_stall,
        output dev_req, dev_we, dev_addr, dev_wdata, dev_be,
        input  dev_ack, dev_rdata,
        input  dm_addr, dm_wdata, dm_be, dm_we, dm_pc,
        output dm_rdata
    );

    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_be, cpu_err, cpu_pc,
        output cpu_rdata, cpu_stall,
        input  dev_req, dev_we, dev_addr, dev_wdata, dev_be,
        output dev_ack, dev_rdata,
        output dm_addr, dm_wdata, dm_be, dm_we, dm_pc,
        input  dm_rdata
    );
endinterface

// File: rtl/dm_access_arbiter.sv
// Shares the single data-memory port between the CPU Mem stage (fixed
// priority) and one secondary device. A contended-cycle counter forces a
// device cycle after MAX_WAIT losses, stalling the CPU for that cycle.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   bus          : arbiter side of dm_access_arbiter_if (CPU, device, DM)
//   dbg_state    : current FSM state
//   dbg_owner    : current port owner (combinational)
//   dbg_wait_cnt : contended-cycle counter
module dm_access_arbiter
    import dm_access_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter logic [31:0] DEV_PC   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    dm_access_arbiter_if.slave   bus,
    output arb_state_t           dbg_state,
    output arb_owner_t           dbg_owner,
    output logic [WAIT_W-1:0]    dbg_wait_cnt
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    arb_state_t          state, state_next;
    arb_owner_t          owner;
    logic [WAIT_W-1:0]   wait_cnt, wait_next;
    logic                ack_q;
    logic [31:0]         rdata_q;

    // Owner selection. The device is never granted in ACK so a request
    // still held during its own ack cycle cannot be served twice.
    always_comb begin
        owner = OWN_NONE;
        unique case (state)
            ARB_NORM: begin
                if (bus.cpu_valid)    owner = OWN_CPU;
                else if (bus.dev_req) owner = OWN_DEV;
            end
            ARB_FORCE: begin
                if (bus.dev_req)        owner = OWN_DEV;
                else if (bus.cpu_valid) owner = OWN_CPU;
            end
            ARB_ACK: begin
                if (bus.cpu_valid) owner = OWN_CPU;
            end
            default: owner = OWN_NONE;
        endcase
    end

    // Next state and contended-cycle counter.
    always_comb begin
        state_next = state;
        wait_next  = wait_cnt;
        unique case (state)
            ARB_NORM: begin
                if (owner == OWN_DEV) begin
                    state_next = ARB_ACK;
                    wait_next  = '0;
                end else if (bus.cpu_valid && bus.dev_req) begin
                    wait_next = sat_inc(wait_cnt);
                    if (wait_next >= MAX_WAIT_C) state_next = ARB_FORCE;
                end else begin
                    wait_next = '0;
                end
            end
            ARB_FORCE: begin
                // Either the forced grant happens or the device withdrew;
                // both leave the counter clear.
                wait_next  = '0;
                state_next = (owner == OWN_DEV) ? ARB_ACK : ARB_NORM;
            end
            ARB_ACK: begin
                state_next = ARB_NORM;
            end
            default: begin
                state_next = ARB_NORM;
                wait_next  = '0;
            end
        endcase
    end

    // Port mux. A faulting CPU access keeps its address but never writes.
    always_comb begin
        bus.dm_addr  = '0;
        bus.dm_wdata = '0;
        bus.dm_be    = '0;
        bus.dm_we    = 1'b0;
        bus.dm_pc    = '0;
        unique case (owner)
            OWN_CPU: begin
                bus.dm_addr  = bus.cpu_addr;
                bus.dm_wdata = bus.cpu_wdata;
                bus.dm_be    = bus.cpu_be & ~{4{bus.cpu_err}};
                bus.dm_we    = bus.cpu_we & ~bus.cpu_err;
                bus.dm_pc    = bus.cpu_pc;
            end
            OWN_DEV: begin
                bus.dm_addr  = bus.dev_addr;
                bus.dm_wdata = bus.dev_wdata;
                bus.dm_be    = bus.dev_be;
                bus.dm_we    = bus.dev_we;
                bus.dm_pc    = DEV_PC;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ARB_NORM;
            wait_cnt <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_next;
            ack_q    <= (owner == OWN_DEV);
            // Captured on device writes too; the value is then meaningless.
            if (owner == OWN_DEV) rdata_q <= bus.dm_rdata;
        end
    end

    assign bus.cpu_rdata = bus.dm_rdata;
    assign bus.cpu_stall = bus.cpu_valid && (owner == OWN_DEV);
    assign bus.dev_ack   = ack_q;
    assign bus.dev_rdata = rdata_q;

    assign dbg_state    = state;
    assign dbg_owner    = owner;
    assign dbg_wait_cnt = wait_cnt;

endmodule

// File: doc/dm_access_arbiter.md
Name: dm_access_arbiter

Overview:
Shares the single data-memory (DM) port between the CPU Mem stage and one secondary requester (DMA/debug device).
- The CPU has fixed priority.
- A wait counter guarantees the device is served within MAX_WAIT contended cycles; it then steals one cycle and stalls the CPU.
- The block sits between the Mem-stage address/byte-enable logic and DM, and drives a stall into the hazard unit.

Parameters:
MAX_WAIT, 4, consecutive contended cycles the device may lose before a forced device cycle (legal range 1..7)
DEV_PC, 32'h0000_0000, value driven on dm_pc for device writes (DM write-log marker)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
cpu_valid  in  1  Mem stage holds a load or store this cycle
cpu_we  in  1  CPU store
cpu_addr  in  32  CPU byte address
cpu_wdata  in  32  CPU store data (already bypassed)
cpu_be  in  4  CPU byte enables
cpu_err  in  1  Mem-stage exception; suppresses the CPU write
cpu_pc  in  32  PC of the Mem-stage instruction
cpu_rdata  out  32  DM read data for the CPU
cpu_stall  out  1  CPU denied the port this cycle
dev_req  in  1  device request, held until dev_ack
dev_we, dev_addr[32], dev_wdata[32], dev_be[4]  in  device transaction fields
dev_ack  out  1  one-cycle completion pulse
dev_rdata  out  32  registered device read data, valid while dev_ack=1
dm_addr, dm_wdata  out  32  to DM
dm_be  out  4  to DM
dm_we  out  1  to DM
dm_pc  out  32  to DM WritePC
dm_rdata  in  32  combinational DM read data

Behaviour:
- States: NORM, FORCE, ACK. Reset (asynchronous, immediate): state=NORM, wait_cnt=0, dev_ack=0, dev_rdata=0.
- Owner selection (combinational):
  - NORM: cpu_valid → CPU; else dev_req → DEV; else NONE.
  - FORCE: dev_req → DEV; else CPU if cpu_valid, else NONE.
  - ACK: CPU if cpu_valid, else NONE. The device is never granted in ACK, even if dev_req is still high.
- Port mux:
  - CPU owns: dm_addr=cpu_addr, dm_wdata=cpu_wdata, dm_be=cpu_be & ~{4{cpu_err}}, dm_we=cpu_we & ~cpu_err, dm_pc=cpu_pc.
  - DEV owns: dev fields, dm_pc=DEV_PC.
  - NONE: all-zero, dm_we=0.
- cpu_stall = cpu_valid && owner==DEV. cpu_rdata = dm_rdata at all times; it is meaningful only when the CPU owns the port.
- Device grant in cycle T:
  - DM write commits at the posedge ending T.
  - dev_rdata <= dm_rdata at that posedge; reads are captured for writes too (don't-care).
  - dev_ack=1 during T+1 only; state=ACK during T+1; wait_cnt <= 0.
- ACK → NORM unconditionally after one cycle. Device latency is 1 cycle uncontended, at most MAX_WAIT+1 cycles after the first contended cycle.
- wait_cnt is 3 bits, saturating.
  - NORM with cpu_valid && dev_req: increment.
  - NORM with !dev_req: clear.
  - On reaching MAX_WAIT: next state=FORCE, so the device owns the port in the following cycle.
- FORCE with dev_req low (device withdrew): no grant, wait_cnt=0, → NORM.
- A dev_req deasserted before grant is dropped silently. The device must not change its fields while dev_req=1.
- A CPU stall repeats the same Mem-stage access next cycle. The arbiter does not latch CPU fields.
- Reset mid-transaction: a pending dev_ack is cleared at once, and no ack is issued for a grant cycle cut by reset.

Decomposition:
- Shared parameter header, alongside the existing CPU constants: state encodings (ARB_NORM=2'd0, ARB_FORCE=2'd1, ARB_ACK=2'd2) and owner encodings (OWN_NONE, OWN_CPU, OWN_DEV).
- No sub-module is needed. Owner mux, FSM and counter live in one module.

Test Plan:
- Idle device: CPU sw addr 0x10, data 0xDEADBEEF, be 4'hF, every cycle → dm_we=1, cpu_stall=0, dev_ack never asserts.
- Device alone: lw addr 0x20 (DM holds 0x12345678) asserted at cycle 5 → DEV owns cycle 5; dev_ack=1 and dev_rdata=0x12345678 in cycle 6; device not re-granted in cycle 6 even with dev_req held.
- Contention, MAX_WAIT=4: cpu_valid and dev_req both high from cycle 0 → CPU owns cycles 0-3; FORCE in cycle 4, device owns it and cpu_stall=1; dev_ack in cycle 5; CPU owns again in cycle 5.
- cpu_err=1 on a CPU sw with be 4'hF → dm_be=0, dm_we=0; DM contents unchanged on readback.
- Withdrawal: dev_req drops in the FORCE cycle → owner=CPU, cpu_stall=0, no dev_ack, wait_cnt=0.
- Asynchronous reset asserted mid-cycle during ACK → dev_ack and dev_rdata go to 0 before the next edge; state=NORM after release.
